// File: rtl/seed_ctrl_pkg.sv
// Seed spacing trigger shared definitions.
// FSM encoding and queue limits.
package seed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE,
    ST_HOLDOFF
  } state_e;

  localparam logic [1:0] PENDING_MAX = 2'd3;

endpackage

// File: rtl/distance_accumulator.sv
// Encoder delta classification and distance accumulator.
// Raises crossing when the travelled distance reaches one seed spacing.
module distance_accumulator #(
  parameter int COUNTER_WIDTH = 32,
  parameter int SPACING_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     clear,
  input  logic [COUNTER_WIDTH-1:0] position,
  input  logic [SPACING_WIDTH-1:0] spacing_in,
  input  logic                     spacing_load,
  output logic                     crossing
);

  logic [COUNTER_WIDTH-1:0] position_q;
  logic [COUNTER_WIDTH-1:0] delta;
  logic                     primed;
  logic [SPACING_WIDTH-1:0] spacing_reg;
  logic [SPACING_WIDTH-1:0] acc;
  logic [SPACING_WIDTH-1:0] acc_inc;
  logic                     active;
  logic                     step_up;
  logic                     step_dn;
  logic                     hit;

  assign delta   = position - position_q;
  assign acc_inc = acc + SPACING_WIDTH'(1);
  assign active  = primed && run && (spacing_reg != '0);
  assign step_up = active && (delta == COUNTER_WIDTH'(1));
  assign step_dn = active && (delta == '1);
  assign hit     = step_up && (acc_inc == spacing_reg);

  // A fresh spacing or an abort throws away a same-cycle crossing.
  assign crossing = hit && !spacing_load && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position_q  <= '0;
      primed      <= 1'b0;
      spacing_reg <= '0;
      acc         <= '0;
    end else begin
      position_q <= position;
      primed     <= 1'b1;
      if (spacing_load) begin
        spacing_reg <= spacing_in;
        acc         <= '0;
      end else if (clear || hit) begin
        acc <= '0;
      end else if (step_up) begin
        acc <= acc_inc;
      end else if (step_dn && (acc != '0)) begin
        acc <= acc - SPACING_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/seed_spacing_trigger.sv
// Seed planter solenoid trigger: queues drops per spacing,
// fires fixed-width pulses with a dead time between them.
module seed_spacing_trigger
  import seed_ctrl_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 32,
  parameter int SPACING_WIDTH  = 16,
  parameter int PULSE_CYCLES   = 5000,
  parameter int HOLDOFF_CYCLES = 2000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] position,
  input  logic                     fault_in,
  input  logic [SPACING_WIDTH-1:0] spacing_in,
  input  logic                     spacing_load,
  input  logic                     clear_stats,
  output logic                     seed_pulse,
  output logic [SPACING_WIDTH-1:0] seed_count,
  output logic [1:0]               pending,
  output logic                     miss,
  output logic                     busy
);

  localparam int TMAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ?
                        PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_e                   state;
  state_e                   state_next;
  logic [TW-1:0]            timer;
  logic [TW-1:0]            timer_next;
  logic                     abort;
  logic                     take;
  logic                     fired;
  logic                     crossing;
  logic                     miss_set;
  logic                     pulse_next;
  logic                     busy_next;
  logic                     miss_next;
  logic [1:0]               pending_next;
  logic [SPACING_WIDTH-1:0] count_next;

  assign abort = !enable || fault_in;

  distance_accumulator #(
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .SPACING_WIDTH(SPACING_WIDTH)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (state != ST_IDLE),
    .clear       (abort),
    .position    (position),
    .spacing_in  (spacing_in),
    .spacing_load(spacing_load),
    .crossing    (crossing)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      seed_pulse <= 1'b0;
      busy       <= 1'b0;
      pending    <= '0;
      miss       <= 1'b0;
      seed_count <= '0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      seed_pulse <= pulse_next;
      busy       <= busy_next;
      pending    <= pending_next;
      miss       <= miss_next;
      seed_count <= count_next;
    end
  end

  // The ARMED check is also made on HOLDOFF exit, so queued drops
  // are spaced by exactly the dead time.
  always_comb begin
    state_next = state;
    timer_next = timer;
    take       = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
      timer_next = '0;
    end else begin
      unique case (state)
        ST_IDLE: state_next = ST_ARMED;
        ST_ARMED: take = (pending != '0);
        ST_FIRE: begin
          if (timer == '0) begin
            state_next = ST_HOLDOFF;
            timer_next = TW'(HOLDOFF_CYCLES - 1);
          end else begin
            timer_next = timer - TW'(1);
          end
        end
        ST_HOLDOFF: begin
          if (timer == '0) begin
            state_next = ST_ARMED;
            take       = (pending != '0);
          end else begin
            timer_next = timer - TW'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
      if (take) begin
        state_next = ST_FIRE;
        timer_next = TW'(PULSE_CYCLES - 1);
      end
    end
  end

  always_comb begin
    pulse_next   = (state_next == ST_FIRE);
    busy_next    = (state_next == ST_FIRE) ||
                   (state_next == ST_HOLDOFF);
    fired        = (state == ST_FIRE) &&
                   (state_next == ST_HOLDOFF);
    miss_set     = 1'b0;
    pending_next = pending;
    if (abort) begin
      pending_next = '0;
    end else if (crossing && !take) begin
      if (pending == PENDING_MAX) miss_set = 1'b1;
      else pending_next = pending + 2'd1;
    end else if (take && !crossing) begin
      pending_next = pending - 2'd1;
    end
    miss_next  = miss || miss_set;
    count_next = seed_count;
    if (fired) count_next = seed_count + SPACING_WIDTH'(1);
    if (clear_stats) begin
      miss_next  = 1'b0;
      count_next = '0;
    end
  end

endmodule

// File: tb/tb_seed_spacing_trigger.sv
// Self-checking bench for seed_spacing_trigger.
// Directed scenarios checked against a timing-level model.
module tb_seed_spacing_trigger;

  localparam int P = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] position = '0;
  logic        fault_in = 1'b0;
  logic [15:0] spacing_in = '0;
  logic        spacing_load = 1'b0;
  logic        clear_stats = 1'b0;
  logic        seed_pulse;
  logic [15:0] seed_count;
  logic [1:0]  pending;
  logic        miss;
  logic        busy;

  seed_spacing_trigger #(
    .COUNTER_WIDTH (32),
    .SPACING_WIDTH (16),
    .PULSE_CYCLES  (P),
    .HOLDOFF_CYCLES(H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .position    (position),
    .fault_in    (fault_in),
    .spacing_in  (spacing_in),
    .spacing_load(spacing_load),
    .clear_stats (clear_stats),
    .seed_pulse  (seed_pulse),
    .seed_count  (seed_count),
    .pending     (pending),
    .miss        (miss),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: machine described by remaining pulse/dead-time cycles.
  bit          m_active, m_primed, m_miss, m_cross, m_take, m_abort;
  int          m_fire_left, m_hold_left, m_pending;
  logic [15:0] m_count, m_acc, m_spacing;
  logic [31:0] m_pos_q, m_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_primed = 0; m_miss = 0;
      m_fire_left = 0; m_hold_left = 0; m_pending = 0;
      m_count = 0; m_acc = 0; m_spacing = 0; m_pos_q = 0;
    end else begin
      m_abort = !enable || fault_in;
      m_cross = 0;
      m_take  = 0;
      m_d = position - m_pos_q;
      if (m_primed && m_active && m_spacing != 0
          && !spacing_load && !m_abort) begin
        if (m_d == 1) begin
          m_acc = m_acc + 1;
          if (m_acc == m_spacing) begin
            m_acc = 0;
            m_cross = 1;
          end
        end else if (m_d == 32'hFFFF_FFFF && m_acc != 0) begin
          m_acc = m_acc - 1;
        end
      end
      if (spacing_load) begin
        m_spacing = spacing_in;
        m_acc = 0;
      end else if (m_abort) begin
        m_acc = 0;
      end
      m_pos_q = position;
      m_primed = 1;
      if (m_abort) begin
        m_active = 0; m_fire_left = 0; m_hold_left = 0;
        m_pending = 0;
      end else if (!m_active) begin
        m_active = 1;
      end else begin
        if (m_fire_left > 0) begin
          m_fire_left--;
          if (m_fire_left == 0) begin
            m_hold_left = H;
            m_count = m_count + 1;
          end
        end else if (m_hold_left > 0) begin
          m_hold_left--;
          if (m_hold_left == 0 && m_pending > 0) m_take = 1;
        end else if (m_pending > 0) begin
          m_take = 1;
        end
        if (m_take) m_fire_left = P;
        if (m_cross && !m_take) begin
          if (m_pending == 3) m_miss = 1;
          else m_pending++;
        end else if (m_take && !m_cross) begin
          m_pending--;
        end
      end
      if (clear_stats) begin
        m_count = 0;
        m_miss = 0;
      end
    end
  end

  int pulses = 0;
  int width = 0;
  int low_len = 0;
  bit prev_pulse = 0;
  bit gap_chk = 0;
  bit have_fall = 0;
  bit abort_pulse = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("seed_pulse", seed_pulse, m_fire_left > 0);
      chk("busy", busy, (m_fire_left > 0) || (m_hold_left > 0));
      chk("pending", pending, m_pending);
      chk("miss", miss, m_miss);
      chk("seed_count", seed_count, m_count);
      chk("acc", dut.u_acc.acc, m_acc);
      if (!gap_chk) have_fall = 0;
      if (seed_pulse && !prev_pulse) begin
        pulses++;
        if (gap_chk && have_fall) chk("gap", low_len, H);
        width = 1;
      end else if (seed_pulse) begin
        width++;
      end else if (prev_pulse) begin
        if (!abort_pulse) chk("width", width, P);
        have_fall = gap_chk;
        low_len = 1;
      end else begin
        low_len++;
      end
      prev_pulse = seed_pulse;
    end else begin
      prev_pulse = 0;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_spacing(logic [15:0] s);
    @(negedge clk);
    spacing_in = s;
    spacing_load = 1'b1;
    @(negedge clk);
    spacing_load = 1'b0;
  endtask

  task automatic step(int n, int gap, bit up);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      position = up ? position + 1 : position - 1;
      cyc(gap);
    end
  endtask

  int p0;
  int n;

  initial begin
    #1;
    chk("rst_pulse", seed_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", seed_count, 0);
    cyc(2);
    rst_n = 1'b1;

    // 25 steps at spacing 10
    load_spacing(16'd10);
    @(negedge clk);
    enable = 1'b1;
    cyc(2);
    p0 = pulses;
    step(25, 1, 1);
    cyc(30);
    chk("s1_pulses", pulses - p0, 2);
    chk("s1_count", seed_count, 2);
    chk("s1_acc", dut.u_acc.acc, 5);
    chk("s1_miss", miss, 0);

    // position wrap
    @(negedge clk);
    enable = 1'b0;
    position = 32'hFFFF_FFFE;
    load_spacing(16'd3);
    enable = 1'b1;
    cyc(2);
    p0 = pulses;
    step(3, 1, 1);
    cyc(20);
    chk("s2_pulses", pulses - p0, 1);
    chk("s2_acc", dut.u_acc.acc, 0);
    chk("s2_count", seed_count, 3);

    // saturation and miss
    @(negedge clk);
    enable = 1'b0;
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("s3_clr_count", seed_count, 0);
    load_spacing(16'd1);
    gap_chk = 1;
    enable = 1'b1;
    cyc(2);
    p0 = pulses;
    step(6, 0, 1);
    @(negedge clk);
    chk("s3_pending", pending, 3);
    chk("s3_miss", miss, 1);
    cyc(40);
    chk("s3_pulses", pulses - p0, 4);
    chk("s3_count", seed_count, 4);
    gap_chk = 0;

    // jump and reverse
    @(negedge clk);
    enable = 1'b0;
    position = 32'd100;
    load_spacing(16'd10);
    enable = 1'b1;
    cyc(2);
    p0 = pulses;
    step(4, 1, 1);
    @(negedge clk);
    position = 32'd5000;
    cyc(2);
    chk("s4_jump_acc", dut.u_acc.acc, 4);
    step(3, 1, 0);
    step(3, 1, 1);
    cyc(2);
    chk("s4_net_acc", dut.u_acc.acc, 4);
    chk("s4_pulses", pulses - p0, 0);

    // fault in 2nd FIRE cycle
    load_spacing(16'd2);
    step(4, 0, 1);
    @(negedge clk);
    chk("s5_fire2_pulse", seed_pulse, 1);
    chk("s5_fire2_pending", pending, 1);
    abort_pulse = 1;
    fault_in = 1'b1;
    @(negedge clk);
    chk("s5_pulse", seed_pulse, 0);
    chk("s5_busy", busy, 0);
    chk("s5_pending", pending, 0);
    chk("s5_count", seed_count, 4);
    fault_in = 1'b0;
    cyc(3);
    abort_pulse = 0;

    // async reset mid-HOLDOFF
    step(2, 1, 1);
    n = 0;
    while (!(busy && !seed_pulse) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s6_holdoff_reached", n < 40, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_pulse", seed_pulse, 0);
    chk("s6_busy", busy, 0);
    chk("s6_pending", pending, 0);
    chk("s6_miss", miss, 0);
    chk("s6_count", seed_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    chk("s6_count_after", seed_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
